tdm_mux_8_1: RTL and testbench

TDM_MUX_8_1 -- requirements
Module: tdm_mux_8_1

---
 rtl/tdm_mux_8_1_if.sv | 43 ++++
 rtl/tdm_mux_8_1.sv | 95 +++++++++
 tb/tb_tdm_mux_8_1.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_mux_8_1_if.sv
// tdm_mux_8_1_if: bundle of frame-request, channel inputs and serialized outputs of the 8:1 TDM mux.
// Optional TDM_MUX_8_1_PARITY_EN adds Parity_Out.
`default_nettype none

interface tdm_mux_8_1_if;
    logic       Enable_In;
    logic       Data_0_In;
    logic       Data_1_In;
    logic       Data_2_In;
    logic       Data_3_In;
    logic       Data_4_In;
    logic       Data_5_In;
    logic       Data_6_In;
    logic       Data_7_In;
    logic       Data_Out;
    logic [2:0] Select_Out;
    logic       Valid_Out;
    logic       Frame_Start_Out;
    logic [7:0] Frame_Count_Out;
`ifdef TDM_MUX_8_1_PARITY_EN
    logic       Parity_Out;
`endif

    modport master (
        output Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
               Data_4_In, Data_5_In, Data_6_In, Data_7_In,
        input  Data_Out, Select_Out, Valid_Out, Frame_Start_Out, Frame_Count_Out
`ifdef TDM_MUX_8_1_PARITY_EN
        , input Parity_Out
`endif
    );

    modport slave (
        input  Enable_In, Data_0_In, Data_1_In, Data_2_In, Data_3_In,
               Data_4_In, Data_5_In, Data_6_In, Data_7_In,
        output Data_Out, Select_Out, Valid_Out, Frame_Start_Out, Frame_Count_Out
`ifdef TDM_MUX_8_1_PARITY_EN
        , output Parity_Out
`endif
    );
endinterface

`default_nettype wire

// File: rtl/tdm_mux_8_1.sv
// tdm_mux_8_1: snapshots eight channel bits and serializes them one slot per clock, back-to-back frames.
// Optional TDM_MUX_8_1_PARITY_EN adds a registered frame parity output.
`default_nettype none

module tdm_mux_8_1 (
    input  wire logic    Clock_In,
    input  wire logic    Reset_In,
    tdm_mux_8_1_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] r_state;
    logic [2:0] r_slot;
    logic [7:0] r_shadow;
    logic       r_data;
    logic [2:0] r_sel;
    logic       r_valid;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic [7:0] w_snap;
    logic       w_last;
    logic       w_start;
    logic [2:0] w_next;

    assign w_snap  = {bus.Data_7_In, bus.Data_6_In, bus.Data_5_In, bus.Data_4_In,
                      bus.Data_3_In, bus.Data_2_In, bus.Data_1_In, bus.Data_0_In};
    assign w_last  = (r_state == S_RUN) && (r_slot == 3'd7);
    // A new frame can start from idle or seamlessly on the edge that ends slot 7
    assign w_start = bus.Enable_In && ((r_state == S_IDLE) || w_last);
    assign w_next  = r_slot + 3'd1;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state       <= S_IDLE;
            r_slot        <= 3'd0;
            r_shadow      <= 8'd0;
            r_data        <= 1'b0;
            r_sel         <= 3'd0;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            if (w_last) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_start) begin
                r_state       <= S_RUN;
                r_slot        <= 3'd0;
                r_shadow      <= w_snap;
                r_data        <= bus.Data_0_In;
                r_sel         <= 3'd0;
                r_valid       <= 1'b1;
                r_frame_start <= 1'b1;
            end else if ((r_state == S_RUN) && !w_last) begin
                r_slot        <= w_next;
                r_data        <= r_shadow[w_next];
                r_sel         <= w_next;
                r_valid       <= 1'b1;
                r_frame_start <= 1'b0;
            end else begin
                r_state       <= S_IDLE;
                r_slot        <= 3'd0;
                r_data        <= 1'b0;
                r_sel         <= 3'd0;
                r_valid       <= 1'b0;
                r_frame_start <= 1'b0;
            end
        end
    end

    assign bus.Data_Out        = r_data;
    assign bus.Select_Out      = r_sel;
    assign bus.Valid_Out       = r_valid;
    assign bus.Frame_Start_Out = r_frame_start;
    assign bus.Frame_Count_Out = r_frame_count;

`ifdef TDM_MUX_8_1_PARITY_EN
    logic r_parity;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_parity <= 1'b0;
        end else if (w_start) begin
            r_parity <= ^w_snap;
        end
    end

    assign bus.Parity_Out = r_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_mux_8_1.sv
// tb_tdm_mux_8_1: scoreboard bench for the 8:1 TDM mux; expected slots queued at snapshot edges.
`default_nettype none

module tb_tdm_mux_8_1;
    logic clk;
    logic rst;

    tdm_mux_8_1_if bus ();

    tdm_mux_8_1 dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       d;
        logic [2:0] sel;
        logic       fs;
        logic       par;
    } exp_t;

    exp_t       sb[$];
    int         m_left;
    logic [7:0] exp_count;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_data(input logic [7:0] v);
        bus.Data_0_In = v[0];
        bus.Data_1_In = v[1];
        bus.Data_2_In = v[2];
        bus.Data_3_In = v[3];
        bus.Data_4_In = v[4];
        bus.Data_5_In = v[5];
        bus.Data_6_In = v[6];
        bus.Data_7_In = v[7];
    endtask

    // Reference: decide at each edge from pre-edge inputs, compare 1 time unit later
    always @(posedge clk) begin
        logic [7:0] snap;
        exp_t       e;
        snap = {bus.Data_7_In, bus.Data_6_In, bus.Data_5_In, bus.Data_4_In,
                bus.Data_3_In, bus.Data_2_In, bus.Data_1_In, bus.Data_0_In};
        if (rst) begin
            sb.delete();
            m_left    = 0;
            exp_count = 8'd0;
        end else if (m_left <= 1) begin
            if (m_left == 1) exp_count = exp_count + 8'd1;
            if (bus.Enable_In) begin
                for (int k = 0; k < 8; k++) begin
                    e.d   = snap[k];
                    e.sel = 3'(k);
                    e.fs  = (k == 0);
                    e.par = ^snap;
                    sb.push_back(e);
                end
                m_left = 8;
            end else begin
                m_left = 0;
            end
        end else begin
            m_left = m_left - 1;
        end
        #1;
        if (!rst) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid", 32'(bus.Valid_Out), 32'd1);
                check("data", 32'(bus.Data_Out), 32'(e.d));
                check("select", 32'(bus.Select_Out), 32'(e.sel));
                check("frame_start", 32'(bus.Frame_Start_Out), 32'(e.fs));
`ifdef TDM_MUX_8_1_PARITY_EN
                check("parity", 32'(bus.Parity_Out), 32'(e.par));
`endif
            end else begin
                check("idle_valid", 32'(bus.Valid_Out), 32'd0);
                check("idle_data", 32'(bus.Data_Out), 32'd0);
                check("idle_select", 32'(bus.Select_Out), 32'd0);
                check("idle_frame_start", 32'(bus.Frame_Start_Out), 32'd0);
            end
            check("frame_count", 32'(bus.Frame_Count_Out), 32'(exp_count));
        end
    end

    task automatic one_frame(input logic [7:0] v);
        set_data(v);
        bus.Enable_In = 1'b1;
        @(negedge clk);
        bus.Enable_In = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.Enable_In = 1'b0;
        set_data(8'h00);
        #2;
        check("reset_valid", 32'(bus.Valid_Out), 32'd0);
        check("reset_data", 32'(bus.Data_Out), 32'd0);
        check("reset_count", 32'(bus.Frame_Count_Out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame with the reference pattern
        one_frame(8'b1010_0110);
        check("single_frame_count", 32'(bus.Frame_Count_Out), 32'd1);

        // Three back-to-back frames, new data before each snapshot edge
        bus.Enable_In = 1'b1;
        for (int f = 0; f < 3; f++) begin
            set_data(8'($urandom));
            repeat (8) @(negedge clk);
        end
        bus.Enable_In = 1'b0;
        repeat (10) @(negedge clk);
        check("three_frames_count", 32'(bus.Frame_Count_Out), 32'd4);

        // Enable drop and input change mid-frame must not disturb the frame
        set_data(8'b0101_1001);
        bus.Enable_In = 1'b1;
        repeat (3) @(negedge clk);
        set_data(8'hFF);
        @(negedge clk);
        bus.Enable_In = 1'b0;
        repeat (6) @(negedge clk);
        check("after_frame_valid", 32'(bus.Valid_Out), 32'd0);

        // Asynchronous reset between edges at slot 5
        set_data(8'hA5);
        bus.Enable_In = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_reset_select", 32'(bus.Select_Out), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(bus.Valid_Out), 32'd0);
        check("async_data", 32'(bus.Data_Out), 32'd0);
        check("async_select", 32'(bus.Select_Out), 32'd0);
        check("async_frame_start", 32'(bus.Frame_Start_Out), 32'd0);
        check("async_count", 32'(bus.Frame_Count_Out), 32'd0);
        bus.Enable_In = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 255 back-to-back frames, then one more to wrap the counter
        set_data(8'h5A);
        bus.Enable_In = 1'b1;
        repeat (255 * 8) @(negedge clk);
        bus.Enable_In = 1'b0;
        repeat (3) @(negedge clk);
        check("count_255", 32'(bus.Frame_Count_Out), 32'd255);
        one_frame(8'hC3);
        check("count_wrap", 32'(bus.Frame_Count_Out), 32'd0);

        // Parity-relevant patterns and a few random frames
        one_frame(8'b0000_0111);
        one_frame(8'b1010_0110);
        for (int f = 0; f < 4; f++) one_frame(8'($urandom));
        check("final_count", 32'(bus.Frame_Count_Out), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
